mem_port_arbiter: RTL and testbench

//  Two-requester round-robin arbiter/sequencer for the word-addressed data memory (Add[7:2], Write, Clk).

---
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter.sv | 110 +++++++++++
 tb/tb_mem_port_arbiter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   r0_* / r1_* : requester handshakes (req/we/add/wdata in, ack/rdata out)
//   mem_*       : single-port word memory (add/write/wdata out, rdata in)
//   busy        : arbiter has an access in flight (GRANT or ACK)
// slave  : arbiter view
// master : requester + memory view (testbench / surrounding system)
interface mem_port_arbiter_if #(
  parameter int AW = 6,
  parameter int DW = 32
);
  logic          r0_req;
  logic          r0_we;
  logic [AW-1:0] r0_add;
  logic [DW-1:0] r0_wdata;
  logic          r0_ack;
  logic [DW-1:0] r0_rdata;

  logic          r1_req;
  logic          r1_we;
  logic [AW-1:0] r1_add;
  logic [DW-1:0] r1_wdata;
  logic          r1_ack;
  logic [DW-1:0] r1_rdata;

  logic [AW-1:0] mem_add;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  r0_req, r0_we, r0_add, r0_wdata,
    input  r1_req, r1_we, r1_add, r1_wdata,
    input  mem_rdata,
    output r0_ack, r0_rdata, r1_ack, r1_rdata,
    output mem_add, mem_write, mem_wdata, busy
  );

  modport master (
    output r0_req, r0_we, r0_add, r0_wdata,
    output r1_req, r1_we, r1_add, r1_wdata,
    output mem_rdata,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata,
    input  mem_add, mem_write, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter/sequencer for the word-addressed data
// memory. Latches one request, drives the memory for one cycle (GRANT),
// captures read data and pulses the winner's ack for one cycle (ACK).
// Ports:
//   Clk   : clock, all state changes on rising edge
//   Rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (requester handshakes + memory port)
// Every output is a flop; no input reaches an output combinationally.
module mem_port_arbiter #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic               Clk,
  input  logic               Rst_n,
  mem_port_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  // requester lanes packed so requester index selects directly
  logic [1:0]         req, we;
  logic [1:0][AW-1:0] add;
  logic [1:0][DW-1:0] wdata;
  logic [1:0]         ack;
  logic [1:0][DW-1:0] rdata;

  assign req   = {bus.r1_req,   bus.r0_req};
  assign we    = {bus.r1_we,    bus.r0_we};
  assign add   = {bus.r1_add,   bus.r0_add};
  assign wdata = {bus.r1_wdata, bus.r0_wdata};

  logic [1:0]    state;
  logic          ptr;   // tie-break winner while IDLE
  logic          sel;   // requester owning the current access
  logic [AW-1:0] mem_add;
  logic          mem_write;
  logic [DW-1:0] mem_wdata;
  logic          busy;

  assign bus.r0_ack    = ack[0];
  assign bus.r1_ack    = ack[1];
  assign bus.r0_rdata  = rdata[0];
  assign bus.r1_rdata  = rdata[1];
  assign bus.mem_add   = mem_add;
  assign bus.mem_write = mem_write;
  assign bus.mem_wdata = mem_wdata;
  assign bus.busy      = busy;

  // From IDLE the pointer breaks ties; from ACK only the other requester
  // may be picked, so the just-acked requester's req is ignored there.
  logic win, pick;
  assign win  = (req[0] & req[1]) ? ptr : req[1];
  assign pick = (state == ACK) ? ~sel : win;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      sel       <= 1'b0;
      mem_add   <= '0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      ack       <= '0;
      rdata     <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            sel       <= pick;
            mem_add   <= add[pick];
            mem_wdata <= wdata[pick];
            mem_write <= we[pick];
            busy      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // memory commits the write on this same edge; rdata is pre-write
          rdata[sel] <= bus.mem_rdata;
          ack[sel]   <= 1'b1;
          mem_write  <= 1'b0;
          state      <= ACK;
        end
        ACK: begin
          ptr <= ~sel;
          if (req[pick]) begin
            sel       <= pick;
            mem_add   <= add[pick];
            mem_wdata <= wdata[pick];
            mem_write <= we[pick];
            state     <= GRANT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          mem_write <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic Clk, Rst_n;
  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // memory model: combinational read, write on rising edge
  logic [DW-1:0] mem [64];
  logic [DW-1:0] shadow [64];
  always @(posedge Clk) if (bus.mem_write) mem[bus.mem_add] <= bus.mem_wdata;
  assign bus.mem_rdata = mem[bus.mem_add];

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endfunction

  // scoreboard of expected acks in completion order
  typedef struct { bit who; logic [DW-1:0] rdata; } exp_t;
  exp_t q[$];

  always @(negedge Clk) begin
    if (bus.r0_ack || bus.r1_ack) begin
      exp_t e;
      if (bus.r0_ack && bus.r1_ack) chk("dual_ack", 1'b1, 1'b0);
      else begin
        chk("ack_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("ack_who", bus.r1_ack, e.who);
          chk("ack_rdata", bus.r1_ack ? bus.r1_rdata : bus.r0_rdata, e.rdata);
        end
      end
    end
  end

  typedef struct {
    bit r0_req; bit r0_we; logic [AW-1:0] r0_add; logic [DW-1:0] r0_wdata;
    bit r1_req; bit r1_we; logic [AW-1:0] r1_add; logic [DW-1:0] r1_wdata;
    bit exp_first;
  } vec_t;
  vec_t vecs[7];

  task automatic push_exp(input bit who, input logic [AW-1:0] a, input bit w, input logic [DW-1:0] d);
    exp_t e;
    e.who = who;
    e.rdata = shadow[a];
    q.push_back(e);
    if (w) shadow[a] = d;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n_req, n_ack, n_wr, exp_wr;
    int cyc_a[2];
    bit order[2];
    n_req = int'(v.r0_req) + int'(v.r1_req);
    order[0] = (v.r0_req && v.r1_req) ? v.exp_first : v.r1_req;
    order[1] = ~order[0];
    exp_wr = 0;
    cyc_a[0] = 0; cyc_a[1] = 0;
    for (int k = 0; k < n_req; k++) begin
      if (order[k]) begin push_exp(1'b1, v.r1_add, v.r1_we, v.r1_wdata); exp_wr += int'(v.r1_we); end
      else          begin push_exp(1'b0, v.r0_add, v.r0_we, v.r0_wdata); exp_wr += int'(v.r0_we); end
    end
    bus.r0_req = v.r0_req; bus.r0_we = v.r0_we; bus.r0_add = v.r0_add; bus.r0_wdata = v.r0_wdata;
    bus.r1_req = v.r1_req; bus.r1_we = v.r1_we; bus.r1_add = v.r1_add; bus.r1_wdata = v.r1_wdata;
    n_ack = 0; n_wr = 0;
    for (int c = 1; c <= 16 && n_ack < n_req; c++) begin
      @(negedge Clk);
      if (bus.mem_write) n_wr++;
      if (bus.r0_ack) begin bus.r0_req = 1'b0; if (n_ack < 2) cyc_a[n_ack] = c; n_ack++; end
      if (bus.r1_ack) begin bus.r1_req = 1'b0; if (n_ack < 2) cyc_a[n_ack] = c; n_ack++; end
    end
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    chk($sformatf("v%0d_acks", idx), n_ack, n_req);
    if (n_req > 0) chk($sformatf("v%0d_lat_first", idx), cyc_a[0], 2);
    if (n_req > 1) chk($sformatf("v%0d_lat_second", idx), cyc_a[1], 4);
    chk($sformatf("v%0d_write_cycles", idx), n_wr, exp_wr);
    @(negedge Clk);
  endtask

  initial begin
    int c0, c1;
    bit got;
    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hA000_0000 + i;
      shadow[i] = 32'hA000_0000 + i;
    end
    vecs[0] = '{1'b1, 1'b0, 6'h05, 32'h0,        1'b1, 1'b0, 6'h06, 32'h0,        1'b0}; // tie after reset
    vecs[1] = '{1'b1, 1'b1, 6'h0C, 32'h3,        1'b0, 1'b0, 6'h00, 32'h0,        1'b0}; // r0 write
    vecs[2] = '{1'b1, 1'b0, 6'h0C, 32'h0,        1'b0, 1'b0, 6'h00, 32'h0,        1'b0}; // r0 read back 3
    vecs[3] = '{1'b1, 1'b1, 6'h30, 32'h111,      1'b1, 1'b1, 6'h30, 32'h222,      1'b1}; // tie, ptr favours r1
    vecs[4] = '{1'b1, 1'b0, 6'h30, 32'h0,        1'b1, 1'b0, 6'h30, 32'h0,        1'b1}; // both read 0x30
    vecs[5] = '{1'b0, 1'b0, 6'h00, 32'h0,        1'b1, 1'b1, 6'h20, 32'hDEADBEEF, 1'b1}; // r1 write
    vecs[6] = '{1'b1, 1'b1, 6'h00, 32'h55AA55AA, 1'b1, 1'b0, 6'h3F, 32'h0,        1'b0}; // edges of address range

    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_add = '0; bus.r0_wdata = '0;
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_add = '0; bus.r1_wdata = '0;
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_mem_write", bus.mem_write, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_acks", {bus.r0_ack, bus.r1_ack}, 2'b00);
    chk("rst_mem_add_wdata", {bus.mem_add, bus.mem_wdata}, '0);
    Rst_n = 1'b1;

    // reset in the middle of a GRANT write
    bus.r0_req = 1'b1; bus.r0_we = 1'b1; bus.r0_add = 6'h0C; bus.r0_wdata = 32'h3;
    @(negedge Clk);
    chk("grant_mem_write", bus.mem_write, 1'b1);
    chk("grant_busy", bus.busy, 1'b1);
    chk("grant_mem_add", bus.mem_add, 6'h0C);
    #2 Rst_n = 1'b0;
    #1;
    chk("async_rst_mem_write", bus.mem_write, 1'b0);
    chk("async_rst_busy", bus.busy, 1'b0);
    chk("async_rst_mem_add_wdata", {bus.mem_add, bus.mem_wdata}, '0);
    bus.r0_req = 1'b0; bus.r0_we = 1'b0; bus.r0_add = '0; bus.r0_wdata = '0;
    repeat (2) @(negedge Clk);
    chk("abort_no_ack", {bus.r0_ack, bus.r1_ack}, 2'b00);
    Rst_n = 1'b1;
    @(negedge Clk);
    chk("post_rst_outputs", {bus.mem_write, bus.busy, bus.r0_ack, bus.r1_ack, bus.mem_add}, '0);
    chk("post_rst_rdata", {bus.r0_rdata, bus.r1_rdata}, '0);
    chk("abort_no_write", mem[6'h0C], 32'hA000_000C);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // fairness: both held for 8 accesses, pointer is at r0 here
    for (int k = 0; k < 4; k++) begin
      push_exp(1'b0, 6'h05, 1'b0, 32'h0);
      push_exp(1'b1, 6'h06, 1'b0, 32'h0);
    end
    bus.r0_req = 1'b1; bus.r0_we = 1'b0; bus.r0_add = 6'h05;
    bus.r1_req = 1'b1; bus.r1_we = 1'b0; bus.r1_add = 6'h06;
    c0 = 0; c1 = 0;
    for (int c = 0; c < 40 && (c0 < 4 || c1 < 4); c++) begin
      @(negedge Clk);
      if (bus.r0_ack) begin c0++; if (c0 == 4) bus.r0_req = 1'b0; end
      if (bus.r1_ack) begin c1++; if (c1 == 4) bus.r1_req = 1'b0; end
    end
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    chk("fair_r0_acks", c0, 4);
    chk("fair_r1_acks", c1, 4);
    repeat (2) @(negedge Clk);
    chk("fair_idle_busy", bus.busy, 1'b0);

    // freeze: request fields change and req drops during GRANT
    push_exp(1'b1, 6'h01, 1'b1, 32'h1234_5678);
    bus.r1_req = 1'b1; bus.r1_we = 1'b1; bus.r1_add = 6'h01; bus.r1_wdata = 32'h1234_5678;
    @(negedge Clk);
    chk("freeze_grant_add", bus.mem_add, 6'h01);
    chk("freeze_grant_wdata", bus.mem_wdata, 32'h1234_5678);
    bus.r1_req = 1'b0; bus.r1_we = 1'b0; bus.r1_add = 6'h02; bus.r1_wdata = 32'hFF;
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge Clk);
      if (bus.r1_ack) got = 1'b1;
    end
    chk("freeze_ack", got, 1'b1);
    chk("freeze_word1", mem[6'h01], 32'h1234_5678);
    chk("freeze_word2", mem[6'h02], 32'hA000_0002);

    repeat (3) @(negedge Clk);
    chk("end_idle", {bus.busy, bus.mem_write}, 2'b00);
    chk("mem_0c", mem[6'h0C], 32'h3);
    chk("mem_30", mem[6'h30], 32'h111);
    chk("mem_20", mem[6'h20], 32'hDEADBEEF);
    chk("sb_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
